// File: rtl/alu_pkg.sv
// Shared ALU datapath constants used by the logic-unit result path.
package alu_pkg;
    localparam int ALU_WIDTH = 4;
    localparam int BUF_DEPTH = 4;
endpackage

// File: rtl/alu_result_buf_if.sv
// Producer/consumer bundle of the result buffer; the master drives stimulus, the slave is the buffer.
interface alu_result_buf_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = BUF_DEPTH
);
    logic [WIDTH-1:0]         res_in;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_zero;
    logic                     out_ones;
    logic                     out_valid;
    logic                     out_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output res_in, res_valid, out_ready, flush,
        input  res_ready, out_data, out_zero, out_ones, out_valid, count, overflow
    );

    modport slave (
        input  res_in, res_valid, out_ready, flush,
        output res_ready, out_data, out_zero, out_ones, out_valid, count, overflow
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Zero / all-ones detector for an ALU result; purely combinational, flags forced low when not valid.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             zero_o,
    output logic             ones_o
);
    assign zero_o = valid_i && (data_i == '0);
    assign ones_o = valid_i && (&data_i);
endmodule

// File: rtl/alu_result_buf.sv
// Show-ahead result FIFO: push visible 1 cycle later, pop exposes next entry immediately.
// Refuses input when full (ready from registered count) and records the drop in a sticky overflow flag.
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_buf_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic res_ready, out_valid, push, pop;

    assign res_ready = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.res_valid && res_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (bus.res_valid && !res_ready) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem_q[wr_ptr_q] <= bus.res_in;
    end

    assign bus.res_ready = res_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .data_i  (mem_q[rd_ptr_q]),
        .valid_i (out_valid),
        .zero_o  (bus.out_zero),
        .ones_o  (bus.out_ones)
    );
endmodule
